// File: rtl/pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_controller
//   Freeze/flush controller for a 5-stage pipeline. It handles SRAM memory
//   stalls (with a timeout that latches into FAULT), taken-branch flushes, and
//   data hazards (a bubble is inserted into ID/EX). It also keeps saturating
//   performance counters for stall and flush cycles.
//
//   Build option: define FORWARDING_EN when the datapath has full forwarding.
//   Only load-use then stalls. Without it, any RAW match against EXE or MEM
//   stalls.
//
// Parameters
//   CNT_WIDTH   : width of stall_count / flush_count
//   MEM_TIMEOUT : MEM_WAIT cycles without mem_ready before entering FAULT
//
// Ports
//   clk, rst                      : clock, synchronous active-high reset
//   id_src1/2, id_src1_valid,
//   id_two_src                    : ID-stage source registers and read flags
//   exe_dest, exe_wb_en,
//   exe_mem_read                  : EXE-stage destination / load indication
//   mem_dest, mem_wb_en           : MEM-stage destination
//   exe_branch_taken              : branch resolved taken in EXE
//   mem_access, mem_ready         : MEM-stage SRAM request / completion
//   *_freeze, *_flush             : per-register load inhibits and flushes
//   hazard                        : data-hazard bubble being inserted
//   mem_timeout                   : sticky memory timeout flag
//   state                         : FSM encoding (RUN=00, MEM_WAIT=01, FAULT=10)
//   stall_count, flush_count      : saturating performance counters
// ---------------------------------------------------------------------------
module pipeline_hazard_controller #(
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           id_src1,
  input  logic [3:0]           id_src2,
  input  logic                 id_src1_valid,
  input  logic                 id_two_src,
  input  logic [3:0]           exe_dest,
  input  logic                 exe_wb_en,
  input  logic                 exe_mem_read,
  input  logic [3:0]           mem_dest,
  input  logic                 mem_wb_en,
  input  logic                 exe_branch_taken,
  input  logic                 mem_access,
  input  logic                 mem_ready,
  output logic                 pc_freeze,
  output logic                 if_id_freeze,
  output logic                 id_ex_freeze,
  output logic                 exe_mem_freeze,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 hazard,
  output logic                 mem_timeout,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    FAULT    = 2'b10
  } state_e;

  state_e                state_q, state_d;
  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic                  mem_timeout_q, mem_timeout_d;
  logic [CNT_WIDTH-1:0]  stall_count_q, stall_count_d;
  logic [CNT_WIDTH-1:0]  flush_count_q, flush_count_d;

  logic src1_exe, src2_exe, src1_mem, src2_mem;
  logic raw_hazard;
  logic mem_stall;
  logic freeze_all, branch_flush, bubble;

  // Source matches only count when that operand is actually read
  assign src1_exe = id_src1_valid && (id_src1 == exe_dest);
  assign src2_exe = id_two_src    && (id_src2 == exe_dest);
  assign src1_mem = id_src1_valid && (id_src1 == mem_dest);
  assign src2_mem = id_two_src    && (id_src2 == mem_dest);

  assign mem_stall = mem_access && !mem_ready;

  // Data-hazard detection; forwarding hides everything except load-use
  always_comb begin
    raw_hazard = 1'b0;
`ifdef FORWARDING_EN
    raw_hazard = exe_wb_en && exe_mem_read && (src1_exe || src2_exe);
`else
    raw_hazard = (exe_wb_en && (src1_exe || src2_exe)) ||
                 (mem_wb_en && (src1_mem || src2_mem));
`endif
  end

  // Next-state and control decode; reset overrides everything
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    freeze_all    = 1'b0;
    branch_flush  = 1'b0;
    bubble        = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_stall) begin
          freeze_all = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end else if (exe_branch_taken) begin
          branch_flush = 1'b1;
        end else if (raw_hazard) begin
          bubble = 1'b1;
        end
      end
      MEM_WAIT: begin
        // A branch held in the frozen EXE register is acted on after release
        if (mem_ready) begin
          state_d = RUN;
        end else begin
          freeze_all = 1'b1;
          if (wait_cnt_q == WAIT_LAST) begin
            state_d       = FAULT;
            mem_timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
      end
      FAULT: begin
        freeze_all = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (rst) begin
      state_d       = RUN;
      wait_cnt_d    = '0;
      mem_timeout_d = 1'b0;
      freeze_all    = 1'b0;
      branch_flush  = 1'b0;
      bubble        = 1'b0;
    end
  end

  assign pc_freeze      = freeze_all || bubble;
  assign if_id_freeze   = freeze_all || bubble;
  assign id_ex_freeze   = freeze_all;
  assign exe_mem_freeze = freeze_all;
  assign if_id_flush    = branch_flush;
  assign id_ex_flush    = branch_flush || bubble;
  assign hazard         = bubble;

  // Saturating performance counters
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (rst) begin
      stall_count_d = '0;
      flush_count_d = '0;
    end else begin
      if (pc_freeze && (stall_count_q != CNT_MAX)) begin
        stall_count_d = stall_count_q + CNT_WIDTH'(1);
      end
      if (if_id_flush && (flush_count_q != CNT_MAX)) begin
        flush_count_d = flush_count_q + CNT_WIDTH'(1);
      end
    end
  end

  // State registers; reset is folded into the _d logic
  always_ff @(posedge clk) begin
    state_q       <= state_d;
    wait_cnt_q    <= wait_cnt_d;
    mem_timeout_q <= mem_timeout_d;
    stall_count_q <= stall_count_d;
    flush_count_q <= flush_count_d;
  end

  assign state       = state_q;
  assign mem_timeout = mem_timeout_q;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_controller
//   Self-checking bench for pipeline_hazard_controller. It uses a small
//   parameterisation (CNT_WIDTH=4, MEM_TIMEOUT=8), so counter saturation and
//   the memory timeout are reached quickly. Directed scenarios run first,
//   then randomized traffic. All of it is checked each cycle against a
//   behavioural model.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_controller;

  localparam int unsigned CW = 4;
  localparam int unsigned MT = 8;

  logic          clk;
  logic          rst;
  logic [3:0]    id_src1, id_src2;
  logic          id_src1_valid, id_two_src;
  logic [3:0]    exe_dest;
  logic          exe_wb_en, exe_mem_read;
  logic [3:0]    mem_dest;
  logic          mem_wb_en;
  logic          exe_branch_taken;
  logic          mem_access, mem_ready;
  logic          pc_freeze, if_id_freeze, id_ex_freeze, exe_mem_freeze;
  logic          if_id_flush, id_ex_flush;
  logic          hazard, mem_timeout;
  logic [1:0]    state;
  logic [CW-1:0] stall_count, flush_count;

  pipeline_hazard_controller #(.CNT_WIDTH(CW), .MEM_TIMEOUT(MT)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_src1          (id_src1),
    .id_src2          (id_src2),
    .id_src1_valid    (id_src1_valid),
    .id_two_src       (id_two_src),
    .exe_dest         (exe_dest),
    .exe_wb_en        (exe_wb_en),
    .exe_mem_read     (exe_mem_read),
    .mem_dest         (mem_dest),
    .mem_wb_en        (mem_wb_en),
    .exe_branch_taken (exe_branch_taken),
    .mem_access       (mem_access),
    .mem_ready        (mem_ready),
    .pc_freeze        (pc_freeze),
    .if_id_freeze     (if_id_freeze),
    .id_ex_freeze     (id_ex_freeze),
    .exe_mem_freeze   (exe_mem_freeze),
    .if_id_flush      (if_id_flush),
    .id_ex_flush      (id_ex_flush),
    .hazard           (hazard),
    .mem_timeout      (mem_timeout),
    .state            (state),
    .stall_count      (stall_count),
    .flush_count      (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: 0 = running, 1 = waiting on memory, 2 = halted on timeout
  int m_mode;
  int m_waited;
  int m_stall;
  int m_flush;
  bit m_tout;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // True when any operand actually read collides with a pending write
  function automatic bit model_hazard();
    int srcs[$];
    bit hit = 1'b0;
    if (id_src1_valid) srcs.push_back(int'(id_src1));
    if (id_two_src)    srcs.push_back(int'(id_src2));
    foreach (srcs[i]) begin
`ifdef FORWARDING_EN
      if (exe_wb_en && exe_mem_read && srcs[i] == int'(exe_dest)) hit = 1'b1;
`else
      if (exe_wb_en && srcs[i] == int'(exe_dest)) hit = 1'b1;
      if (mem_wb_en && srcs[i] == int'(mem_dest)) hit = 1'b1;
`endif
    end
    return hit;
  endfunction

  task automatic model_reset();
    m_mode   = 0;
    m_waited = 0;
    m_stall  = 0;
    m_flush  = 0;
    m_tout   = 1'b0;
  endtask

  // Called at a negedge with inputs applied: check, clock, advance the model
  task automatic run_cycle();
    bit all_frz, br, bub;
    logic [6:0] exp_v, obs_v;
    #1;
    all_frz = 1'b0; br = 1'b0; bub = 1'b0;
    if (!rst) begin
      if (m_mode == 0) begin
        if (mem_access && !mem_ready) all_frz = 1'b1;
        else if (exe_branch_taken)    br = 1'b1;
        else if (model_hazard())      bub = 1'b1;
      end else if (m_mode == 1) begin
        all_frz = !mem_ready;
      end else begin
        all_frz = 1'b1;
      end
    end
    exp_v = {bub, all_frz | bub, all_frz | bub, all_frz, all_frz, br, br | bub};
    obs_v = {hazard, pc_freeze, if_id_freeze, id_ex_freeze, exe_mem_freeze,
             if_id_flush, id_ex_flush};
    check_val("ctrl_outs",   32'(obs_v),       32'(exp_v));
    check_val("state",       32'(state),       32'(m_mode));
    check_val("mem_timeout", 32'(mem_timeout), 32'(m_tout));
    check_val("stall_count", 32'(stall_count), 32'(m_stall));
    check_val("flush_count", 32'(flush_count), 32'(m_flush));

    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if ((all_frz || bub) && m_stall < (1 << CW) - 1) m_stall++;
      if (br && m_flush < (1 << CW) - 1) m_flush++;
      case (m_mode)
        0: if (mem_access && !mem_ready) begin m_mode = 1; m_waited = 0; end
        1: begin
          if (mem_ready) m_mode = 0;
          else begin
            m_waited++;
            if (m_waited >= int'(MT)) begin m_mode = 2; m_tout = 1'b1; end
          end
        end
        default: ;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic set_idle();
    rst = 1'b0;
    id_src1 = '0; id_src2 = '0; id_src1_valid = 1'b0; id_two_src = 1'b0;
    exe_dest = '0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
    mem_dest = 4'd9; mem_wb_en = 1'b0;
    exe_branch_taken = 1'b0; mem_access = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_load_use();
    id_src1 = 4'd3; id_src1_valid = 1'b1;
    exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
  endtask

  int bias;

  initial begin
    set_idle();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_reset();

    // Reset held: outputs quiet, state and counters cleared
    rst = 1'b1; mem_access = 1'b1; set_load_use();
    run_cycle();
    set_idle();
    run_cycle();

    // Load-use hazard, held two cycles so the stall counter moves
    set_load_use();
    run_cycle();
    run_cycle();
    // Plain RAW on an ALU result
    exe_mem_read = 1'b0;
    run_cycle();
    // Second source only, register 15
    set_idle(); id_src2 = 4'd15; id_two_src = 1'b1; mem_dest = 4'd15; mem_wb_en = 1'b1;
    run_cycle();
    // Unread source must not match
    set_idle(); id_src2 = 4'd5; exe_dest = 4'd5; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
    run_cycle();

    // Memory stall: entry cycle plus five waiting cycles, then completion
    set_idle(); mem_access = 1'b1;
    repeat (6) run_cycle();
    mem_ready = 1'b1;
    run_cycle();
    set_idle();
    run_cycle();

    // Branch together with load-use: the flush wins
    set_load_use(); exe_branch_taken = 1'b1;
    run_cycle();
    set_idle();
    run_cycle();

    // Branch arriving during a memory wait is deferred until after release
    mem_access = 1'b1; exe_branch_taken = 1'b1;
    repeat (3) run_cycle();
    mem_ready = 1'b1;
    run_cycle();
    mem_access = 1'b0;
    run_cycle();
    set_idle();
    run_cycle();

    // Counter saturation, then reset
    set_load_use();
    repeat (20) run_cycle();
    rst = 1'b1;
    run_cycle();
    set_idle();
    run_cycle();

    // Timeout into FAULT, which is sticky until reset
    mem_access = 1'b1;
    repeat (12) run_cycle();
    mem_ready = 1'b1; exe_branch_taken = 1'b1;
    repeat (3) run_cycle();
    rst = 1'b1;
    run_cycle();
    set_idle();
    run_cycle();

    // Randomized traffic with alternating memory latency profiles
    bias = 85;
    for (int c = 0; c < 3000; c++) begin
      if (c % 256 == 0) bias = (bias == 85) ? 10 : 85;
      rst              = ($urandom_range(0, 59) == 0);
      id_src1          = 4'($urandom_range(0, 3));
      id_src2          = 4'($urandom_range(0, 3));
      id_src1_valid    = 1'($urandom);
      id_two_src       = 1'($urandom);
      exe_dest         = 4'($urandom_range(0, 3));
      exe_wb_en        = 1'($urandom);
      exe_mem_read     = 1'($urandom);
      mem_dest         = 4'($urandom_range(0, 3));
      mem_wb_en        = 1'($urandom);
      exe_branch_taken = ($urandom_range(0, 7) == 0);
      mem_access       = ($urandom_range(0, 3) == 0);
      mem_ready        = (int'($urandom_range(0, 99)) < bias);
      run_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, width of the performance counters.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 64, the maximum number of MEM_WAIT cycles before fault.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset; it is synchronous and active-high.
REQ-005 SHALL have ports id_src1, id_src2, input, 4 each, the ID-stage source register addresses.
REQ-006 SHALL have ports id_src1_valid, id_two_src, input, 1 each, which mark src1 and src2 as actually read.
REQ-007 SHALL have ports exe_dest, input, 4, and exe_wb_en, exe_mem_read, input, 1, describing the EXE-stage instruction.
REQ-008 SHALL have ports mem_dest, input, 4, and mem_wb_en, input, 1, describing the MEM-stage instruction.
REQ-009 SHALL have port exe_branch_taken, input, 1, asserted when a branch resolves taken in EXE.
REQ-010 SHALL have ports mem_access, input, 1, and mem_ready, input, 1, the MEM-stage request and the SRAM completion.
REQ-011 SHALL have ports pc_freeze, if_id_freeze, id_ex_freeze, exe_mem_freeze, output, 1 each, the per-register load inhibits.
REQ-012 SHALL have ports if_id_flush, id_ex_flush, output, 1 each, the per-register flushes.
REQ-013 SHALL have ports hazard, output, 1; mem_timeout, output, 1 (sticky); state, output, 2.
REQ-014 SHALL have ports stall_count, flush_count, output, CNT_WIDTH each.

Function
REQ-015 SHALL implement an FSM with RUN=00, MEM_WAIT=01, FAULT=10; state SHALL output the current encoding.
REQ-016 In RUN, mem_access=1 with mem_ready=0 SHALL assert all four freezes combinationally in the same cycle and SHALL go to MEM_WAIT next edge.
REQ-017 In MEM_WAIT, all four freezes SHALL stay 1 and both flushes SHALL stay 0; mem_ready=1 SHALL release the freezes in that cycle and SHALL return to RUN.
REQ-018 A wait counter SHALL count MEM_WAIT cycles and clear on entry; if MEM_TIMEOUT cycles elapse without mem_ready, the FSM SHALL go to FAULT.
REQ-019 FAULT SHALL assert all freezes and mem_timeout, and SHALL remain until rst.
REQ-020 In RUN without a memory stall, exe_branch_taken=1 SHALL assert if_id_flush and id_ex_flush for one cycle and SHALL suppress hazard-driven freezes.
REQ-021 In RUN without a memory stall or branch, a detected hazard SHALL assert hazard, pc_freeze, if_id_freeze and id_ex_flush (bubble); id_ex_freeze and exe_mem_freeze SHALL be 0.
REQ-022 Priority SHALL be rst > FAULT > memory stall > branch flush > data hazard > none.
REQ-023 A source match SHALL require its valid flag (id_src1_valid or id_two_src) to be 1; writes to r15 SHALL be treated like any other register.
REQ-024 stall_count SHALL increment on every cycle with pc_freeze=1, and flush_count on every cycle with if_id_flush=1.
REQ-025 Both counters SHALL saturate at all-ones.
REQ-026 A branch during MEM_WAIT SHALL NOT flush; it is held by the frozen EXE register and SHALL be acted on in the first RUN cycle after release.

Reset
REQ-027 rst=1 SHALL force state=RUN, the wait counter=0, stall_count=0, flush_count=0 and mem_timeout=0 at the next edge.
REQ-028 While rst=1, all freeze, flush and hazard outputs SHALL be 0.
REQ-029 Reset asserted mid-MEM_WAIT or in FAULT SHALL abandon the operation with no residual freeze after the edge.

Configuration
REQ-030 With FORWARDING_EN defined, hazard SHALL be asserted only for load-use: exe_mem_read=1, exe_wb_en=1 and a valid source equal to exe_dest.
REQ-031 Without FORWARDING_EN, hazard SHALL be asserted for any valid source equal to exe_dest with exe_wb_en=1, or equal to mem_dest with mem_wb_en=1.

Verification
REQ-032 With FORWARDING_EN, id_src1=3, id_src1_valid=1, exe_dest=3, exe_wb_en=1, exe_mem_read=1 -> hazard=1, pc_freeze=1, id_ex_flush=1, stall_count 0->1.
REQ-033 Same stimulus with exe_mem_read=0 -> hazard=0 with FORWARDING_EN, and hazard=1 without it.
REQ-034 mem_access=1, mem_ready=0 for 5 cycles, then 1 -> state 01 for 5 cycles, all freezes 1, return to 00, stall_count=6.
REQ-035 MEM_TIMEOUT=8, mem_ready held 0 -> state=10 after 8 MEM_WAIT cycles, mem_timeout=1 sticky, cleared only by rst.
REQ-036 exe_branch_taken=1 together with a load-use match -> if_id_flush=1, id_ex_flush=1, pc_freeze=0, flush_count=1.
REQ-037 CNT_WIDTH=4 with 20 consecutive stall cycles -> stall_count saturates at 15; rst -> 0.
